toggle_pulse_scheduler: RTL and testbench
=========================================

TOGGLE_PULSE_SCHEDULER -- requirements
Module: toggle_pulse_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, bits serialized per transaction.
REQ-003 SHALL have parameter CNT_W, default $clog2(DATA_W+1), result width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester request level.
REQ-007 data  input  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
REQ-008 gnt  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 done_id  output  $clog2(N_REQ)  index of the requester completing.
REQ-012 result  output  CNT_W  toggle-pulse count, valid while done=1, held until next done.

Function
REQ-013 SHALL contain one shared toggle-pulse FSM (idle->s0 unconditionally; s0 with din=1 -> s1, dout<=1; s1 with din=1 -> s0, dout<=0; din=0 holds state, dout<=0; registered dout).
REQ-014 SHALL sequence states IDLE -> CLR -> PRIME -> SHIFT (DATA_W cycles) -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: if any req, SHALL pick winner round-robin, latch its data into shift register, latch its index, go CLR; else stay IDLE.
REQ-016 Round-robin: search starts at (last_grant+1) mod N_REQ; last_grant updates only on grant.
REQ-017 CLR: sub-FSM reset asserted (sub_rst = rst | clr) for exactly one cycle; bit counter cleared; result accumulator cleared.
REQ-018 PRIME: sub-FSM din=0 for one cycle so it reaches s0.
REQ-019 SHIFT: din = shift-register MSB each cycle, shift left by one; exit after DATA_W bits.
REQ-020 DRAIN: din=0 for one cycle to capture dout of the last bit.
REQ-021 Accumulator SHALL add dout every cycle in SHIFT and DRAIN; never overflows CNT_W (max ceil(DATA_W/2)).
REQ-022 DONE: done=1, result=accumulator, done_id=latched index, for one cycle.
REQ-023 gnt SHALL be asserted for latched index in CLR through DONE inclusive; zero in IDLE.
REQ-024 Latency: req sampled in IDLE at cycle t -> done high at cycle t+DATA_W+4 (t+12 for default).
REQ-025 req deasserted mid-transaction SHALL be ignored; transaction completes normally.
REQ-026 data changes after grant SHALL not affect the transaction.
REQ-027 Back-to-back: requests present in DONE cycle are arbitrated in the following IDLE cycle (one idle cycle minimum between transactions).
REQ-028 Unreachable state encodings SHALL return to IDLE with all outputs zero.

Reset
REQ-029 rst at any cycle, including mid-SHIFT, SHALL force IDLE, sub-FSM idle, gnt=0, busy=0, done=0, done_id=0, result=0, last_grant=N_REQ-1.
REQ-030 Transaction interrupted by reset SHALL produce no done pulse.

Structure
REQ-031 Shared package toggle_sched_pkg SHALL hold state encoding typedef and default N_REQ/DATA_W constants.
REQ-032 Toggle-pulse FSM SHALL be a separate sub-module toggle_pulse_fsm (ports clk, rst, din, dout).
REQ-033 Arbiter, sequencer FSM, shift register, counters in toggle_pulse_scheduler; target 150-300 RTL lines.

Verification
REQ-034 Single req[0], data0=8'hFF -> gnt=4'b0001 cycles t+1..t+12, done at t+12, result=4, done_id=0.
REQ-035 Single req[2], data2=8'hA5 -> result=2; data2=8'h80 -> result=1; data2=8'h00 -> result=0; data2=8'h07 -> result=2.
REQ-036 req=4'b1111 held after reset -> grant order 0,1,2,3,0; each gnt one-hot; one idle cycle between done and next CLR.
REQ-037 rst pulsed at 5th SHIFT cycle -> next cycle all outputs zero, no done; subsequent req[1] with 8'hFF yields result=4 (sub-FSM restarted from s0).
REQ-038 req[3] dropped and data3 changed after grant -> transaction completes with original data's result, done_id=3.
REQ-039 Assertions: gnt one-hot or zero; done exactly one cycle; busy==(state!=IDLE); result<=ceil(DATA_W/2).

Source files
------------

// File: rtl/toggle_sched_pkg.sv
// Shared types and default sizing for the toggle-pulse scheduler.
package toggle_sched_pkg;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DATA_W = 8;

  // Sequencer states of the scheduler.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_PRIME = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_t;

  // States of the shared toggle-pulse detector.
  typedef enum logic [1:0] {
    TP_IDLE = 2'd0,
    TP_S0   = 2'd1,
    TP_S1   = 2'd2
  } tp_state_t;

endpackage

// File: rtl/toggle_pulse_fsm.sv
// Toggle-pulse detector: emits a registered one-cycle pulse on every
// other '1' seen on din, starting with the first one after idle.
module toggle_pulse_fsm
  import toggle_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  tp_state_t state, state_next;
  logic      dout_next;

  // State and registered pulse output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TP_IDLE;
      dout  <= 1'b0;
    end else begin
      state <= state_next;
      dout  <= dout_next;
    end
  end

  // Next-state and next-pulse decode.
  always_comb begin
    state_next = state;
    dout_next  = 1'b0;
    case (state)
      TP_IDLE: state_next = TP_S0;
      TP_S0: begin
        if (din) begin
          state_next = TP_S1;
          dout_next  = 1'b1;
        end
      end
      TP_S1: begin
        if (din) state_next = TP_S0;
      end
      default: state_next = TP_IDLE;
    endcase
  end

endmodule

// File: rtl/toggle_pulse_scheduler.sv
// Round-robin scheduler that serializes one requester's word through a
// shared toggle-pulse detector and reports the pulse count.
module toggle_pulse_scheduler
  import toggle_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_REQ)-1:0]  done_id,
  output logic [CNT_W-1:0]          result
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  sched_state_t      state, state_next;
  logic [IDX_W-1:0]  last_grant, cur_idx, win_idx;
  logic              win_found;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  acc, result_q;
  logic              clr, sub_rst, din, dout;
  int unsigned       cand;

  assign sub_rst = rst | clr;

  toggle_pulse_fsm u_tp (
    .clk  (clk),
    .rst  (sub_rst),
    .din  (din),
    .dout (dout)
  );

  // Round-robin pick: first requester after the last granted one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last_grant) + off) % N_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Sequencer next-state and output decode.
  always_comb begin
    state_next = state;
    gnt        = '0;
    busy       = 1'b0;
    done       = 1'b0;
    done_id    = '0;
    result     = result_q;
    clr        = 1'b0;
    din        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) state_next = ST_CLR;
      end
      ST_CLR: begin
        busy       = 1'b1;
        clr        = 1'b1;
        state_next = ST_PRIME;
      end
      ST_PRIME: begin
        busy       = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        din  = shreg[DATA_W-1];
        if (bit_cnt == BIT_W'(DATA_W - 1)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        done_id    = cur_idx;
        state_next = ST_IDLE;
      end
      default: begin
        result     = '0;
        state_next = ST_IDLE;
      end
    endcase
    if (busy) gnt[cur_idx] = 1'b1;
  end

  // Datapath: grant latch, shift register, bit counter, accumulator.
  // The result register is loaded on the DRAIN edge with the final sum so it
  // is valid throughout DONE and holds across the next transaction's CLR.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(N_REQ - 1);
      cur_idx    <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            last_grant <= win_idx;
            cur_idx    <= win_idx;
            shreg      <= data[win_idx*DATA_W +: DATA_W];
          end
        end
        ST_CLR: begin
          bit_cnt <= '0;
          acc     <= '0;
        end
        ST_SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + BIT_W'(1);
          acc     <= acc + CNT_W'(dout);
        end
        ST_DRAIN: begin
          acc      <= acc + CNT_W'(dout);
          result_q <= acc + CNT_W'(dout);
        end
        ST_PRIME, ST_DONE: ;
        default: result_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_pulse_scheduler.sv
// Directed bench for toggle_pulse_scheduler with hand-computed results.
module tb_toggle_pulse_scheduler;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req;
  logic [31:0]       data;
  logic [3:0]        gnt;
  logic              busy;
  logic              done;
  logic [1:0]        done_id;
  logic [CNT_W-1:0]  result;

  int checks = 0;
  int fails  = 0;
  logic prev_done = 1'b0;

  toggle_pulse_scheduler #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
    chk("result_max", 32'(result <= 4), 32'd1);
    chk("done_single", 32'(done && prev_done), 32'd0);
    prev_done = done;
  end

  // Runs one transaction whose request was sampled in the current IDLE cycle.
  task automatic txn(input int unsigned idx, input logic [3:0] exp_res,
                     input logic [3:0] req_after, input logic [31:0] data_after);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << idx;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        req  = req_after;
        data = data_after;
      end
      chk($sformatf("gnt_r%0d_c%0d", idx, c), 32'(gnt), 32'(exp_gnt));
      chk($sformatf("busy_r%0d_c%0d", idx, c), 32'(busy), 32'd1);
      chk($sformatf("done_r%0d_c%0d", idx, c), 32'(done), 32'(c == 12));
      if (c == 12) begin
        chk($sformatf("result_r%0d", idx), 32'(result), 32'(exp_res));
        chk($sformatf("done_id_r%0d", idx), 32'(done_id), 32'(idx));
      end
    end
    tick();
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_done_id", 32'(done_id), 32'd0);
    chk("held_result", 32'(result), 32'(exp_res));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_done_id"}, 32'(done_id), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single requester 0 with all ones: four pulses.
    data = 32'h0000_00FF;
    req  = 4'b0001;
    txn(0, 4'd4, 4'b0000, data);

    // Requester 2 with assorted words.
    data = 32'h00A5_0000;
    req  = 4'b0100;
    txn(2, 4'd2, 4'b0000, data);
    data = 32'h0080_0000;
    req  = 4'b0100;
    txn(2, 4'd1, 4'b0000, data);
    data = 32'h0000_0000;
    req  = 4'b0100;
    txn(2, 4'd0, 4'b0000, data);
    data = 32'h0007_0000;
    req  = 4'b0100;
    txn(2, 4'd2, 4'b0000, data);

    // All requesters held after reset: grants rotate 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset2");
    data = 32'h0780_A5FF;
    req  = 4'b1111;
    txn(0, 4'd4, 4'b1111, data);
    txn(1, 4'd2, 4'b1111, data);
    txn(2, 4'd1, 4'b1111, data);
    txn(3, 4'd2, 4'b1111, data);
    txn(0, 4'd4, 4'b0000, data);

    // Reset in the fifth SHIFT cycle aborts without a done pulse.
    data = 32'h0000_FF00;
    req  = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      chk($sformatf("abort_gnt_c%0d", c), 32'(gnt), 32'h2);
      chk($sformatf("abort_done_c%0d", c), 32'(done), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("abort");
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("abort_quiet_done_c%0d", c), 32'(done), 32'd0);
      chk($sformatf("abort_quiet_busy_c%0d", c), 32'(busy), 32'd0);
    end
    req = 4'b0010;
    txn(1, 4'd4, 4'b0000, data);

    // Request dropped and word changed after grant: original word counts.
    data = 32'hA500_0000;
    req  = 4'b1000;
    txn(3, 4'd2, 4'b0000, 32'hFF00_0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
